audio_soft_mute_ctrl: RTL and testbench

Avalon-MM slave that generalises the single-bit audio mute port to CH independently muted channels. Each channel fades a GAIN_W-bit gain down to zero or back up to full scale at a programmable rate, so the audio datapath never switches abruptly. The block sits on the Qsys bus beside the audio core and drives per-channel gain and hard-mute lines into the codec output path.

---
 rtl/audio_soft_mute_pkg.sv | 29 ++
 rtl/audio_soft_mute_if.sv | 14 +
 rtl/audio_soft_mute_ch.sv | 80 ++++++++
 rtl/audio_soft_mute_ctrl.sv | 94 +++++++++
 tb/tb_audio_soft_mute_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_soft_mute_pkg.sv
// Shared types and register map for the per-channel audio soft-mute controller.
package audio_soft_mute_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DIV_W  = 16;

  localparam logic [ADDR_W-1:0] ADDR_REQ    = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_DIV    = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_IRQ    = 2'd3;

  localparam int unsigned STATUS_BUSY_LSB  = 0;
  localparam int unsigned STATUS_MUTED_LSB = 16;

  typedef enum logic [1:0] {
    ST_UNMUTED = 2'd0,
    ST_RAMP_DN = 2'd1,
    ST_MUTED   = 2'd2,
    ST_RAMP_UP = 2'd3
  } ch_state_e;

  // IRQ register image: bit1 pending, bit0 enable
  typedef struct packed {
    logic pending;
    logic enable;
  } irq_reg_t;

endpackage

// File: rtl/audio_soft_mute_if.sv
// Avalon-MM slave bus bundle for the soft-mute controller.
interface audio_soft_mute_if;
  import audio_soft_mute_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/audio_soft_mute_ch.sv
// One channel of the soft mute: ramps gain between full scale and zero on shared ticks.
module audio_soft_mute_ch
  import audio_soft_mute_pkg::*;
#(
  parameter int unsigned GAIN_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              tick,
  output logic [GAIN_W-1:0] gain,
  output logic              mute,
  output logic              busy,
  output logic              done
);

  localparam logic [GAIN_W-1:0] FULL = {GAIN_W{1'b1}};
  localparam logic [GAIN_W-1:0] ONE  = GAIN_W'(1);

  ch_state_e state;

  // A request reversal only changes direction; the next tick steps from the current gain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_UNMUTED;
      gain  <= FULL;
      mute  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_UNMUTED: begin
          if (req) begin
            state <= ST_RAMP_DN;
            busy  <= 1'b1;
          end
        end
        ST_RAMP_DN: begin
          if (!req) begin
            state <= ST_RAMP_UP;
          end else if (tick) begin
            if (gain <= ONE) begin
              gain  <= '0;
              state <= ST_MUTED;
              mute  <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              gain <= gain - ONE;
            end
          end
        end
        ST_MUTED: begin
          if (!req) begin
            state <= ST_RAMP_UP;
            mute  <= 1'b0;
            busy  <= 1'b1;
          end
        end
        ST_RAMP_UP: begin
          if (req) begin
            state <= ST_RAMP_DN;
          end else if (tick) begin
            if (gain >= FULL - ONE) begin
              gain  <= FULL;
              state <= ST_UNMUTED;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              gain <= gain + ONE;
            end
          end
        end
        default: state <= ST_UNMUTED;
      endcase
    end
  end

endmodule

// File: rtl/audio_soft_mute_ctrl.sv
// Avalon-MM soft-mute controller: CH channels sharing one ramp prescaler.
// Define AUDIO_SOFT_MUTE_IRQ_EN to build the ramp-complete interrupt register.
module audio_soft_mute_ctrl
  import audio_soft_mute_pkg::*;
#(
  parameter int unsigned CH          = 2,
  parameter int unsigned GAIN_W      = 8,
  parameter int unsigned DEFAULT_DIV = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  audio_soft_mute_if.slave     bus,
  output logic [CH-1:0]        mute_out,
  output logic [CH*GAIN_W-1:0] gain_out,
  output logic                 irq
);

  logic              wr;
  logic              tick;
  logic [CH-1:0]     req_q;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  presc_q;
  logic [CH-1:0]     busy_vec;
  logic [CH-1:0]     done_vec;
  logic [DATA_W-1:0] irq_rd;
  logic              unused_bits;

  assign wr   = bus.chipselect & ~bus.write_n;
  assign tick = (presc_q == div_q);

  // REQ/DIV registers and the shared prescaler; a DIV write restarts the count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q   <= '0;
      div_q   <= DIV_W'(DEFAULT_DIV);
      presc_q <= '0;
    end else begin
      if (wr && bus.address == ADDR_REQ) req_q <= bus.writedata[CH-1:0];
      if (wr && bus.address == ADDR_DIV) div_q <= bus.writedata[DIV_W-1:0];
      if ((wr && bus.address == ADDR_DIV) || tick) presc_q <= '0;
      else                                         presc_q <= presc_q + DIV_W'(1);
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    audio_soft_mute_ch #(.GAIN_W(GAIN_W)) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req_q[i]),
      .tick    (tick),
      .gain    (gain_out[i*GAIN_W +: GAIN_W]),
      .mute    (mute_out[i]),
      .busy    (busy_vec[i]),
      .done    (done_vec[i])
    );
  end

`ifdef AUDIO_SOFT_MUTE_IRQ_EN
  irq_reg_t irq_q;

  // Completion set takes priority over a simultaneous write-1-to-clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_q <= '0;
    end else begin
      if (wr && bus.address == ADDR_IRQ) irq_q.enable <= bus.writedata[0];
      if (|done_vec)                                            irq_q.pending <= 1'b1;
      else if (wr && bus.address == ADDR_IRQ && bus.writedata[1]) irq_q.pending <= 1'b0;
    end
  end

  assign irq         = irq_q.enable & irq_q.pending;
  assign irq_rd      = DATA_W'(irq_q);
  assign unused_bits = ^bus.writedata[DATA_W-1:DIV_W];
`else
  assign irq         = 1'b0;
  assign irq_rd      = '0;
  assign unused_bits = ^{bus.writedata[DATA_W-1:DIV_W], done_vec};
`endif

  // Zero-wait-state read mux, not qualified by chipselect
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_REQ:    bus.readdata = DATA_W'(req_q);
      ADDR_STATUS: bus.readdata = (DATA_W'(busy_vec) << STATUS_BUSY_LSB) |
                                  (DATA_W'(mute_out) << STATUS_MUTED_LSB);
      ADDR_DIV:    bus.readdata = DATA_W'(div_q);
      ADDR_IRQ:    bus.readdata = irq_rd;
      default:     bus.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_audio_soft_mute_ctrl.sv
// Self-checking bench for audio_soft_mute_ctrl (CH=2, GAIN_W=4) against a behavioural gain-ramp model.
module tb_audio_soft_mute_ctrl;

  localparam int unsigned CH          = 2;
  localparam int unsigned GAIN_W      = 4;
  localparam int unsigned DEFAULT_DIV = 255;
  localparam int          FS          = 15;

  logic                 clk;
  logic                 reset_n;
  logic [CH-1:0]        mute_out;
  logic [CH*GAIN_W-1:0] gain_out;
  logic                 irq;

  audio_soft_mute_if bus_if ();

  audio_soft_mute_ctrl #(.CH(CH), .GAIN_W(GAIN_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus_if),
    .mute_out (mute_out),
    .gain_out (gain_out),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: gain level, ramp direction and settled flags per channel
  int         m_gain [CH];
  bit         m_busy [CH];
  bit         m_mute [CH];
  bit         m_down [CH];
  bit [CH-1:0] m_req;
  int         m_div;
  int         m_since;
  bit         m_en, m_pend, m_done_prev;

  function automatic logic [CH*GAIN_W-1:0] exp_gain();
    logic [CH*GAIN_W-1:0] v;
    for (int c = 0; c < CH; c++) v[c*GAIN_W +: GAIN_W] = GAIN_W'(m_gain[c]);
    return v;
  endfunction

  function automatic logic [CH-1:0] exp_mute();
    logic [CH-1:0] v;
    for (int c = 0; c < CH; c++) v[c] = m_mute[c];
    return v;
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] v = '0;
    for (int c = 0; c < CH; c++) begin
      v[c]      = m_busy[c];
      v[16 + c] = m_mute[c];
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_reg(input int a);
    case (a)
      0: return 32'(m_req);
      1: return exp_status();
      2: return 32'(m_div);
`ifdef AUDIO_SOFT_MUTE_IRQ_EN
      3: return {30'd0, m_pend, m_en};
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic exp_irq();
    return m_en & m_pend;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_gain[c] = FS; m_busy[c] = 0; m_mute[c] = 0; m_down[c] = 0;
    end
    m_req = '0; m_div = DEFAULT_DIV; m_since = 0;
    m_en = 0; m_pend = 0; m_done_prev = 0;
  endtask

  // Advance model by one clock using the bus values about to be sampled, then clock the DUT
  task automatic step();
    bit wr, t, r, anydone, clr;
    int a;
    logic [31:0] d;
    wr = bus_if.chipselect && !bus_if.write_n;
    a  = int'(bus_if.address);
    d  = bus_if.writedata;
    t  = ((m_since % (m_div + 1)) == m_div);
    anydone = 0;
    clr = 0;
    for (int c = 0; c < CH; c++) begin
      r = m_req[c];
      if (!m_busy[c]) begin
        if (r && !m_mute[c]) begin m_busy[c] = 1; m_down[c] = 1; end
        else if (!r && m_mute[c]) begin m_busy[c] = 1; m_down[c] = 0; m_mute[c] = 0; end
      end else if (r != m_down[c]) begin
        m_down[c] = r;
      end else if (t) begin
        if (r) begin
          if (m_gain[c] > 0) m_gain[c]--;
          if (m_gain[c] == 0) begin m_busy[c] = 0; m_mute[c] = 1; anydone = 1; end
        end else begin
          if (m_gain[c] < FS) m_gain[c]++;
          if (m_gain[c] == FS) begin m_busy[c] = 0; anydone = 1; end
        end
      end
    end
`ifdef AUDIO_SOFT_MUTE_IRQ_EN
    if (wr && a == 3) begin m_en = d[0]; clr = d[1]; end
    m_pend = m_done_prev | (m_pend & !clr);
    m_done_prev = anydone;
`else
    if (clr || anydone) m_done_prev = 0;
`endif
    if (wr && a == 0) m_req = d[CH-1:0];
    if (wr && a == 2) begin m_div = int'(d[15:0]); m_since = 0; end
    else m_since++;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input int a, input logic [31:0] data);
    bus_if.address    = 2'(a);
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    bus_if.writedata  = data;
    step();
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.address    = 2'd1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (gain_out !== 8'hFF) begin errors++; $display("FAIL reset_async_gain got %h exp %h", gain_out, 8'hFF); end
    @(negedge clk);
    reset_n = 1'b1;
    step();
    checks++;
    if (gain_out !== 8'hFF) begin errors++; $display("FAIL reset_gain got %h exp %h", gain_out, 8'hFF); end
    checks++;
    if (mute_out !== 2'b00) begin errors++; $display("FAIL reset_mute got %b exp 00", mute_out); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
    checks++;
    if (bus_if.readdata !== 32'd0) begin errors++; $display("FAIL reset_status got %h exp 0", bus_if.readdata); end
    bus_if.address = 2'd2;
    #1 rd = bus_if.readdata;
    checks++;
    if (rd !== 32'd255) begin errors++; $display("FAIL reset_div got %0d exp 255", rd); end
    bus_if.address = 2'd0;
    #1 rd = bus_if.readdata;
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL reset_req got %h exp 0", rd); end
    bus_if.address = 2'd3;
    #1 rd = bus_if.readdata;
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL reset_irqreg got %h exp 0", rd); end
    bus_if.address = 2'd1;
  endtask

  task automatic test_full_mute();
    int mute_cyc = -1;
    logic [GAIN_W-1:0] prev = 4'hF;
    do_reset();
    wr_reg(2, 32'd1);
    wr_reg(0, 32'h1);
    for (int n = 0; n < 40; n++) begin
      step();
      checks++;
      if (gain_out !== exp_gain()) begin errors++; $display("FAIL mute_gain cyc %0d got %h exp %h", n, gain_out, exp_gain()); end
      checks++;
      if (mute_out !== exp_mute()) begin errors++; $display("FAIL mute_out cyc %0d got %b exp %b", n, mute_out, exp_mute()); end
      checks++;
      if (gain_out[7:4] !== 4'hF) begin errors++; $display("FAIL mute_ch1_hold cyc %0d got %h exp f", n, gain_out[7:4]); end
      checks++;
      if (prev - gain_out[3:0] > 1) begin errors++; $display("FAIL mute_step cyc %0d got %h after %h", n, gain_out[3:0], prev); end
      prev = gain_out[3:0];
      if (mute_out[0] && mute_cyc < 0) mute_cyc = n + 1;
    end
    checks++;
    if (mute_cyc < 1 || mute_cyc > 32) begin errors++; $display("FAIL mute_latency got %0d exp 1..32", mute_cyc); end
  endtask

  task automatic test_reversal();
    bit hit = 0;
    int prev;
    do_reset();
    wr_reg(2, 32'd3);
    wr_reg(0, 32'h1);
    for (int n = 0; n < 120 && !hit; n++) begin
      step();
      checks++;
      if (gain_out !== exp_gain()) begin errors++; $display("FAIL rev_down_gain got %h exp %h", gain_out, exp_gain()); end
      if (m_gain[0] == 9) hit = 1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rev_reach9 got timeout exp gain 9"); end
    wr_reg(0, 32'h0);
    prev = int'(gain_out[3:0]);
    for (int n = 0; n < 60; n++) begin
      step();
      checks++;
      if (gain_out !== exp_gain()) begin errors++; $display("FAIL rev_up_gain cyc %0d got %h exp %h", n, gain_out, exp_gain()); end
      checks++;
      if (mute_out !== 2'b00) begin errors++; $display("FAIL rev_mute cyc %0d got %b exp 00", n, mute_out); end
      checks++;
      if (int'(gain_out[3:0]) - prev > 1 || prev - int'(gain_out[3:0]) > 1) begin
        errors++; $display("FAIL rev_jump cyc %0d got %0d after %0d", n, gain_out[3:0], prev);
      end
      checks++;
      if (bus_if.readdata !== exp_status()) begin errors++; $display("FAIL rev_status got %h exp %h", bus_if.readdata, exp_status()); end
      prev = int'(gain_out[3:0]);
    end
    checks++;
    if (gain_out[3:0] !== 4'hF || bus_if.readdata !== 32'd0) begin
      errors++; $display("FAIL rev_final got gain %h status %h exp f / 0", gain_out[3:0], bus_if.readdata);
    end
  endtask

  task automatic test_both();
    do_reset();
    wr_reg(2, 32'd0);
    wr_reg(0, 32'h3);
    for (int n = 0; n < 20; n++) begin
      step();
      checks++;
      if (gain_out !== exp_gain()) begin errors++; $display("FAIL both_gain cyc %0d got %h exp %h", n, gain_out, exp_gain()); end
      checks++;
      if (gain_out[3:0] !== gain_out[7:4]) begin errors++; $display("FAIL both_lockstep cyc %0d got %h vs %h", n, gain_out[3:0], gain_out[7:4]); end
      checks++;
      if (bus_if.readdata !== exp_status()) begin errors++; $display("FAIL both_status cyc %0d got %h exp %h", n, bus_if.readdata, exp_status()); end
    end
    checks++;
    if (bus_if.readdata !== 32'h0003_0000) begin errors++; $display("FAIL both_final got %h exp 00030000", bus_if.readdata); end
  endtask

`ifdef AUDIO_SOFT_MUTE_IRQ_EN
  task automatic test_irq();
    int g0 = -1, i1 = -1;
    bit hit = 0;
    do_reset();
    wr_reg(3, 32'h1);
    wr_reg(2, 32'd0);
    wr_reg(0, 32'h1);
    for (int n = 0; n < 40; n++) begin
      step();
      checks++;
      if (irq !== exp_irq()) begin errors++; $display("FAIL irq_model cyc %0d got %b exp %b", n, irq, exp_irq()); end
      if (gain_out[3:0] == 4'h0 && g0 < 0) g0 = n;
      if (irq && i1 < 0) i1 = n;
    end
    checks++;
    if (g0 < 0 || i1 != g0 + 1) begin errors++; $display("FAIL irq_latency got gain0 %0d irq %0d exp irq=gain0+1", g0, i1); end
    wr_reg(3, 32'h3);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_w1c got %b exp 0", irq); end
    wr_reg(0, 32'h0);
    for (int n = 0; n < 40 && !hit; n++) begin
      if (m_done_prev) hit = 1;
      else step();
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL irq_wait_done got timeout exp completion"); end
    wr_reg(3, 32'h3);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_set_wins got %b exp 1", irq); end
  endtask
`endif

  task automatic test_random();
    int act;
    logic [31:0] rd;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      act = $urandom_range(0, 9);
      case (act)
        0, 1: wr_reg(0, $urandom);
        2:    wr_reg(2, 32'($urandom_range(0, 3)));
        3:    wr_reg(3, 32'($urandom_range(0, 3)));
        4:    wr_reg(1, $urandom);
        default: step();
      endcase
      checks++;
      if (gain_out !== exp_gain() || mute_out !== exp_mute() || irq !== exp_irq()) begin
        errors++;
        $display("FAIL rand_out cyc %0d got g=%h m=%b i=%b exp g=%h m=%b i=%b",
                 n, gain_out, mute_out, irq, exp_gain(), exp_mute(), exp_irq());
      end
      act = $urandom_range(0, 3);
      bus_if.address = 2'(act);
      #1 rd = bus_if.readdata;
      checks++;
      if (rd !== exp_reg(act)) begin errors++; $display("FAIL rand_read addr %0d got %h exp %h", act, rd, exp_reg(act)); end
      bus_if.address = 2'd1;
    end
  endtask

  task automatic test_reset_midramp();
    bit hit = 0;
    do_reset();
    wr_reg(2, 32'd2);
    wr_reg(0, 32'h1);
    for (int n = 0; n < 100 && !hit; n++) begin
      step();
      if (m_gain[0] == 6) hit = 1;
    end
    checks++;
    if (!hit || gain_out[3:0] !== 4'd6 || bus_if.readdata !== exp_status()) begin
      errors++; $display("FAIL rst_mid_pre got gain %h status %h exp 6 / %h", gain_out[3:0], bus_if.readdata, exp_status());
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (gain_out !== 8'hFF) begin errors++; $display("FAIL rst_mid_gain got %h exp ff", gain_out); end
    checks++;
    if (mute_out !== 2'b00) begin errors++; $display("FAIL rst_mid_mute got %b exp 00", mute_out); end
    checks++;
    if (bus_if.readdata !== 32'd0) begin errors++; $display("FAIL rst_mid_status got %h exp 0", bus_if.readdata); end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    bus_if.address    = 2'd1;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = '0;
    model_reset();
    test_reset();
    test_full_mute();
    test_reversal();
    test_both();
`ifdef AUDIO_SOFT_MUTE_IRQ_EN
    test_irq();
`endif
    test_random();
    test_reset_midramp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
